saida_serial_uc: RTL and testbench
==================================

Name: saida_serial_uc

Overview:
- Control unit (UC) that sequences the saida_serial_fd datapath to transmit one 3-digit measurement frame plus a hashtag terminator over the serial line.
- On partida, steps selecao_mux through digit 0, digit 1, digit 2, then terminator code 2'b11.
- Issues one proximo pulse per character and waits for serial_pronto from the datapath before advancing.
- Reports frame completion on pronto.

Parameters:
- NUM_DIGITOS, 3: number of data characters sent before the terminator; legal range 1..3.
- SEL_TERMINADOR, 2'b11: selecao_mux code of the hashtag character.
- TIMEOUT_CICLOS, 50000: cycles allowed per character before abort; used only with SAIDA_SERIAL_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears the block immediately).
- partida  in  1  start request; sampled only in INICIAL.
- serial_pronto  in  1  one-cycle pulse from the datapath at the end of each character.
- proximo  out  1  one-cycle pulse commanding the datapath to load and send the selected character.
- selecao_mux  out  2  registered character select for the datapath.
- ocupado  out  1  high from PREPARA through ESPERA/PROXIMO_DIGITO; low in INICIAL and FINAL.
- pronto  out  1  one-cycle pulse, frame complete.
- erro  out  1  sticky timeout flag; present only with the macro.
- db_estado  out  4  current state encoding, for debug displays.

Behaviour:
- Reset values (reset=0, asynchronous): state INICIAL, indice=0, proximo=0, selecao_mux=2'b00, ocupado=0, pronto=0, erro=0, db_estado=4'h0.
- Reset mid-frame aborts immediately. No pronto is issued, and no further proximo is issued until a new partida.
- State encodings: INICIAL=0, PREPARA=1, TRANSMITE=2, ESPERA=3, PROXIMO_DIGITO=4, FINAL=5, ERRO=6.
- INICIAL: partida=1 goes to PREPARA, otherwise stays.
- PREPARA: indice<=0, selecao_mux<=0; goes to TRANSMITE.
- TRANSMITE: proximo=1 for exactly this cycle; goes to ESPERA.
- ESPERA: serial_pronto=1 goes to PROXIMO_DIGITO, otherwise stays.
- PROXIMO_DIGITO:
  - If indice==NUM_DIGITOS (terminator just sent), goes to FINAL.
  - Otherwise indice<=indice+1, selecao_mux<=(indice+1<NUM_DIGITOS) ? indice+1 : SEL_TERMINADOR, and goes to TRANSMITE.
- FINAL: pronto=1 for one cycle; goes to INICIAL.
- Output registration: selecao_mux is registered and stable from its update until the next PROXIMO_DIGITO. It never changes while the datapath is shifting.
- Latency:
  - partida sampled at edge k puts proximo high in the cycle following edge k+1.
  - serial_pronto sampled at edge e puts the next proximo high in the cycle following edge e+1.
  - serial_pronto of the terminator at edge e puts pronto high in the cycle following edge e+1.
- Frame content: exactly NUM_DIGITOS+1 proximo pulses per frame.
- partida while ocupado=1 or in FINAL is ignored; it is not queued.
- partida held high continuously starts back-to-back frames: INICIAL→PREPARA with one idle cycle between frames.
- serial_pronto outside ESPERA is ignored, including a pulse coincident with the proximo cycle.
- indice is 2 bits wide; it never exceeds NUM_DIGITOS, so it cannot wrap.

Optional Feature:
- Macro: SAIDA_SERIAL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ESPERA and increments each ESPERA cycle.
  - Reaching TIMEOUT_CICLOS-1 without serial_pronto goes to ERRO.
  - ERRO sets erro=1, forces proximo=0 and ocupado=0, and leaves to INICIAL on the next cycle.
  - erro stays set until the next partida is accepted or reset=0.
  - serial_pronto arriving in the same cycle as the limit takes priority: the block advances and does not raise erro.
- Undefined: no counter, no erro port, ERRO is unreachable, and ESPERA waits indefinitely.

Decomposition:
- Package saida_serial_pkg holds:
  - the state encoding typedef and constants (INICIAL..ERRO);
  - SEL_TERMINADOR default 2'b11;
  - the selecao_mux width constant (2).
- One sub-module, saida_serial_timeout (load/enable counter with terminal-count flag), instantiated only under SAIDA_SERIAL_TIMEOUT_EN.

Test Plan:
- Single frame: reset=0 for 2 cycles, partida pulse, serial_pronto pulse 8 cycles after each proximo → 4 proximo pulses with selecao_mux 00,01,10,11; one pronto; ocupado low afterward.
- Spurious handshake: serial_pronto in INICIAL, and serial_pronto coincident with proximo → ignored; no extra advance; proximo count still 4.
- Busy start: partida at the 2nd ESPERA → ignored; exactly one frame and one pronto.
- Reset mid-frame: reset=0 during ESPERA with selecao_mux=2'b10 → all outputs 0 and db_estado=0 asynchronously, no pronto; a following partida restarts at selecao_mux=00.
- NUM_DIGITOS=1: selecao_mux sequence 00 then 11, 2 proximo pulses, pronto once.
- With SAIDA_SERIAL_TIMEOUT_EN and TIMEOUT_CICLOS=16: no serial_pronto → erro=1 after 16 ESPERA cycles, return to INICIAL; next partida clears erro.

Source files
------------

// File: rtl/saida_serial_pkg.sv
// Shared types and constants for the saida_serial control unit.
package saida_serial_pkg;

  localparam int unsigned SelW = 2;
  localparam logic [SelW-1:0] SelTerminador = 2'b11;

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StPrepara       = 4'h1,
    StTransmite     = 4'h2,
    StEspera        = 4'h3,
    StProximoDigito = 4'h4,
    StFinal         = 4'h5,
    StErro          = 4'h6
  } estado_e;

endpackage

// File: rtl/saida_serial_timeout.sv
// Clear/enable cycle counter; tc_o flags the last allowed cycle while enabled.
module saida_serial_timeout #(
  parameter int unsigned Ciclos = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned Width = (Ciclos > 2) ? $clog2(Ciclos) : 1;
  localparam logic [Width-1:0] Limite = Width'(Ciclos - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == Limite);

endmodule

// File: rtl/saida_serial_uc.sv
// Control unit sequencing saida_serial_fd: NUM_DIGITOS digits then the hashtag terminator.
// Define SAIDA_SERIAL_TIMEOUT_EN to add a per-character timeout with a sticky erro_o flag.
module saida_serial_uc
  import saida_serial_pkg::*;
#(
  parameter int unsigned NUM_DIGITOS = 3,
  parameter logic [SelW-1:0] SEL_TERMINADOR = SelTerminador
`ifdef SAIDA_SERIAL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CICLOS = 50000
`endif
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic            partida_i,
  input  logic            serial_pronto_i,
  output logic            proximo_o,
  output logic [SelW-1:0] selecao_mux_o,
  output logic            ocupado_o,
  output logic            pronto_o,
`ifdef SAIDA_SERIAL_TIMEOUT_EN
  output logic            erro_o,
`endif
  output logic [3:0]      db_estado_o
);

  localparam logic [1:0] NumDig = NUM_DIGITOS[1:0];

  estado_e         estado_q, estado_d;
  logic [1:0]      indice_q, indice_d;
  logic [1:0]      indice_inc;
  logic [SelW-1:0] sel_q, sel_d;
  logic            limite;

  assign indice_inc = indice_q + 2'd1;

`ifdef SAIDA_SERIAL_TIMEOUT_EN
  logic erro_q, erro_d;

  saida_serial_timeout #(
    .Ciclos(TIMEOUT_CICLOS)
  ) u_timeout (
    .clk_i  (clock_i),
    .rst_ni (reset_ni),
    .clear_i(estado_q == StTransmite),
    .en_i   (estado_q == StEspera),
    .tc_o   (limite)
  );

  assign erro_o = erro_q;
`else
  assign limite = 1'b0;
`endif

  always_comb begin
    estado_d  = estado_q;
    indice_d  = indice_q;
    sel_d     = sel_q;
    proximo_o = 1'b0;
    pronto_o  = 1'b0;
    ocupado_o = 1'b0;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    erro_d    = erro_q;
`endif
    unique case (estado_q)
      StInicial: begin
        if (partida_i) begin
          estado_d = StPrepara;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
          erro_d   = 1'b0;
`endif
        end
      end
      StPrepara: begin
        ocupado_o = 1'b1;
        indice_d  = '0;
        sel_d     = '0;
        estado_d  = StTransmite;
      end
      StTransmite: begin
        ocupado_o = 1'b1;
        proximo_o = 1'b1;
        estado_d  = StEspera;
      end
      StEspera: begin
        ocupado_o = 1'b1;
        // A handshake on the limit cycle wins over the timeout.
        if (serial_pronto_i) begin
          estado_d = StProximoDigito;
        end else if (limite) begin
          estado_d = StErro;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
          erro_d   = 1'b1;
`endif
        end
      end
      StProximoDigito: begin
        ocupado_o = 1'b1;
        if (indice_q == NumDig) begin
          estado_d = StFinal;
        end else begin
          indice_d = indice_inc;
          sel_d    = (indice_inc < NumDig) ? indice_inc : SEL_TERMINADOR;
          estado_d = StTransmite;
        end
      end
      StFinal: begin
        pronto_o = 1'b1;
        estado_d = StInicial;
      end
      StErro: begin
        estado_d = StInicial;
      end
      default: begin
        estado_d = StInicial;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q <= StInicial;
      indice_q <= '0;
      sel_q    <= '0;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      sel_q    <= sel_d;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign selecao_mux_o = sel_q;
  assign db_estado_o   = estado_q;

endmodule

// File: tb/tb_saida_serial_uc.sv
// Randomized self-checking bench: unit 0 sends 3 digits, unit 1 sends 1 digit.
module tb_saida_serial_uc;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       partida [2];
  logic       sp      [2];
  logic       proximo [2];
  logic [1:0] sel     [2];
  logic       ocupado [2];
  logic       pronto  [2];
  logic [3:0] db      [2];
`ifdef SAIDA_SERIAL_TIMEOUT_EN
  logic       erro    [2];
`endif

  int nchk = 0;
  int nfail = 0;
  int npx [2];
  int npr [2];

  always #5 clock = ~clock;

  saida_serial_uc #(
    .NUM_DIGITOS(3)
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    , .TIMEOUT_CICLOS(16)
`endif
  ) dut0 (
    .clock_i        (clock),
    .reset_ni       (rst_n),
    .partida_i      (partida[0]),
    .serial_pronto_i(sp[0]),
    .proximo_o      (proximo[0]),
    .selecao_mux_o  (sel[0]),
    .ocupado_o      (ocupado[0]),
    .pronto_o       (pronto[0]),
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    .erro_o         (erro[0]),
`endif
    .db_estado_o    (db[0])
  );

  saida_serial_uc #(
    .NUM_DIGITOS(1)
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    , .TIMEOUT_CICLOS(16)
`endif
  ) dut1 (
    .clock_i        (clock),
    .reset_ni       (rst_n),
    .partida_i      (partida[1]),
    .serial_pronto_i(sp[1]),
    .proximo_o      (proximo[1]),
    .selecao_mux_o  (sel[1]),
    .ocupado_o      (ocupado[1]),
    .pronto_o       (pronto[1]),
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    .erro_o         (erro[1]),
`endif
    .db_estado_o    (db[1])
  );

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (proximo[k] === 1'b1) npx[k]++;
      if (pronto[k] === 1'b1) npr[k]++;
    end
  end

  function automatic int ndig_of(input int u);
    return (u == 0) ? 3 : 1;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge that shows it idle again.
  task automatic run_frame(input int u, input int fixed_d, input bit spur, input bit busy,
                           input bit hold, input int abort_ch);
    int nd, d, px0, pr0;
    logic [1:0] exp_sel;
    nd  = ndig_of(u);
    px0 = npx[u];
    pr0 = npr[u];
    partida[u] = 1'b1;
    @(negedge clock);
    partida[u] = hold;
    nchk++;
    if (proximo[u] !== 1'b0 || ocupado[u] !== 1'b1 || db[u] !== 4'h1) begin
      nfail++;
      $display("FAIL prepara u%0d: proximo=%b ocupado=%b db=%h want 0 1 1", u, proximo[u],
               ocupado[u], db[u]);
    end
    for (int i = 0; i <= nd; i++) begin
      exp_sel = (i < nd) ? 2'(i) : 2'b11;
      @(negedge clock);
      nchk++;
      if (proximo[u] !== 1'b1 || sel[u] !== exp_sel || ocupado[u] !== 1'b1) begin
        nfail++;
        $display("FAIL transmite u%0d ch%0d: proximo=%b sel=%b ocupado=%b want 1 %b 1", u, i,
                 proximo[u], sel[u], ocupado[u], exp_sel);
      end
      sp[u] = spur;
      d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 8));
      for (int j = 0; j < d; j++) begin
        @(negedge clock);
        if (i == abort_ch && j == 0) begin
          nchk++;
          if (sel[u] !== exp_sel) begin
            nfail++;
            $display("FAIL pre_abort_sel u%0d: got %b want %b", u, sel[u], exp_sel);
          end
          sp[u] = 1'b0;
          partida[u] = 1'b0;
          #2 rst_n = 1'b0;
          #1;
          nchk++;
          if (proximo[u] !== 1'b0 || sel[u] !== 2'b00 || ocupado[u] !== 1'b0 ||
              pronto[u] !== 1'b0 || db[u] !== 4'h0) begin
            nfail++;
            $display("FAIL async_reset u%0d: proximo=%b sel=%b ocupado=%b pronto=%b db=%h",
                     u, proximo[u], sel[u], ocupado[u], pronto[u], db[u]);
          end
          @(negedge clock);
          @(negedge clock);
          rst_n = 1'b1;
          repeat (3) @(negedge clock);
          nchk++;
          if (npr[u] != pr0 || npx[u] - px0 != i + 1 || db[u] !== 4'h0) begin
            nfail++;
            $display("FAIL after_abort u%0d: pronto_n=%0d proximo_n=%0d db=%h want 0 %0d 0",
                     u, npr[u] - pr0, npx[u] - px0, db[u], i + 1);
          end
          return;
        end
        nchk++;
        if (proximo[u] !== 1'b0 || sel[u] !== exp_sel || ocupado[u] !== 1'b1 ||
            pronto[u] !== 1'b0) begin
          nfail++;
          $display("FAIL espera u%0d ch%0d: proximo=%b sel=%b ocupado=%b pronto=%b want 0 %b 1 0",
                   u, i, proximo[u], sel[u], ocupado[u], pronto[u], exp_sel);
        end
        partida[u] = hold | (busy && i == 1 && j == 0);
        sp[u] = (j == d - 1);
      end
      @(negedge clock);
      sp[u] = 1'b0;
      partida[u] = hold;
      nchk++;
      if (proximo[u] !== 1'b0 || db[u] !== 4'h4) begin
        nfail++;
        $display("FAIL proximo_digito u%0d ch%0d: proximo=%b db=%h want 0 4", u, i, proximo[u],
                 db[u]);
      end
    end
    @(negedge clock);
    nchk++;
    if (pronto[u] !== 1'b1 || ocupado[u] !== 1'b0 || proximo[u] !== 1'b0) begin
      nfail++;
      $display("FAIL final u%0d: pronto=%b ocupado=%b proximo=%b want 1 0 0", u, pronto[u],
               ocupado[u], proximo[u]);
    end
    @(negedge clock);
    nchk++;
    if (pronto[u] !== 1'b0 || ocupado[u] !== 1'b0 || db[u] !== 4'h0) begin
      nfail++;
      $display("FAIL inicial u%0d: pronto=%b ocupado=%b db=%h want 0 0 0", u, pronto[u],
               ocupado[u], db[u]);
    end
    nchk++;
    if (npx[u] - px0 != nd + 1 || npr[u] - pr0 != 1) begin
      nfail++;
      $display("FAIL frame_count u%0d: proximo_n=%0d pronto_n=%0d want %0d 1", u, npx[u] - px0,
               npr[u] - pr0, nd + 1);
    end
  endtask

  task automatic idle(input int u, input int n, input bit pulse_sp);
    for (int c = 0; c < n; c++) begin
      sp[u] = pulse_sp;
      @(negedge clock);
      nchk++;
      if (proximo[u] !== 1'b0 || ocupado[u] !== 1'b0 || db[u] !== 4'h0) begin
        nfail++;
        $display("FAIL idle u%0d: proximo=%b ocupado=%b db=%h want 0 0 0", u, proximo[u],
                 ocupado[u], db[u]);
      end
    end
    sp[u] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      partida[u] = 1'b0;
      sp[u] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      nchk++;
      if (proximo[u] !== 1'b0 || sel[u] !== 2'b00 || ocupado[u] !== 1'b0 ||
          pronto[u] !== 1'b0 || db[u] !== 4'h0) begin
        nfail++;
        $display("FAIL reset u%0d: proximo=%b sel=%b ocupado=%b pronto=%b db=%h want all 0",
                 u, proximo[u], sel[u], ocupado[u], pronto[u], db[u]);
      end
`ifdef SAIDA_SERIAL_TIMEOUT_EN
      nchk++;
      if (erro[u] !== 1'b0) begin
        nfail++;
        $display("FAIL reset_erro u%0d: got %b want 0", u, erro[u]);
      end
`endif
    end
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_frame;
    run_frame(0, 8, 1'b0, 1'b0, 1'b0, -1);
    idle(0, 3, 1'b0);
  endtask

  task automatic test_spurious;
    idle(0, 3, 1'b1);
    run_frame(0, 0, 1'b1, 1'b0, 1'b0, -1);
    idle(0, 2, 1'b0);
  endtask

  task automatic test_busy_start;
    run_frame(0, 4, 1'b0, 1'b1, 1'b0, -1);
    idle(0, 5, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    run_frame(0, 3, 1'b0, 1'b0, 1'b0, 2);
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, -1);
    idle(0, 2, 1'b0);
  endtask

  task automatic test_num_digitos_1;
    for (int f = 0; f < 4; f++) begin
      run_frame(1, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
      idle(1, 1 + $urandom_range(0, 2), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    run_frame(0, 0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(0, 0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(0, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
    idle(0, 2, 1'b0);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
      idle(0, 1, 1'b0);
    end
  endtask

`ifdef SAIDA_SERIAL_TIMEOUT_EN
  task automatic test_timeout;
    partida[0] = 1'b1;
    @(negedge clock);
    partida[0] = 1'b0;
    @(negedge clock);
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      nchk++;
      if (db[0] !== 4'h3 || erro[0] !== 1'b0) begin
        nfail++;
        $display("FAIL timeout_wait cyc%0d: db=%h erro=%b want 3 0", j, db[0], erro[0]);
      end
    end
    @(negedge clock);
    nchk++;
    if (db[0] !== 4'h6 || erro[0] !== 1'b1 || ocupado[0] !== 1'b0 || proximo[0] !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_erro: db=%h erro=%b ocupado=%b proximo=%b want 6 1 0 0", db[0],
               erro[0], ocupado[0], proximo[0]);
    end
    @(negedge clock);
    nchk++;
    if (db[0] !== 4'h0 || erro[0] !== 1'b1) begin
      nfail++;
      $display("FAIL timeout_sticky: db=%h erro=%b want 0 1", db[0], erro[0]);
    end
    partida[0] = 1'b1;
    @(negedge clock);
    partida[0] = 1'b0;
    nchk++;
    if (db[0] !== 4'h1 || erro[0] !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_clear: db=%h erro=%b want 1 0", db[0], erro[0]);
    end
    @(negedge clock);
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      sp[0] = (j == 15);
    end
    @(negedge clock);
    sp[0] = 1'b0;
    nchk++;
    if (db[0] !== 4'h4 || erro[0] !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_priority: db=%h erro=%b want 4 0", db[0], erro[0]);
    end
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    idle(0, 2, 1'b0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_spurious();
    test_busy_start();
    test_reset_mid_frame();
    test_num_digitos_1();
    test_back_to_back();
`ifdef SAIDA_SERIAL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
